phase_scheduler: RTL and testbench

Four-approach intersection phase scheduler. It grants the green phase to one approach at a time using demand-driven round-robin, with minimum and maximum green times, yellow and all-red clearance intervals, force-red masking, and an attention (flash) mode. It sits between the sensor/request inputs and the per-approach lamp drivers. It replaces fixed sequential enabling of the traffic lights with a timed, request-aware arbiter.

---
 rtl/phase_scheduler.sv | 118 +++++++++++
 tb/tb_phase_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_scheduler.sv
// phase_scheduler: four-approach round-robin green arbiter with min/max green, clearance and flash.
// Define PHASE_SCHED_PREEMPT_EN to turn pref into a preemption input.
module phase_scheduler #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int TW        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            attention,
    input  logic [3:0]      req,
    input  logic [3:0]      pref,
    input  logic [3:0]      force_red,
    output logic [3:0][2:0] lights,
    output logic [1:0]      green_idx,
    output logic [1:0]      phase
);
    localparam logic [1:0] S_AR = 2'd0;
    localparam logic [1:0] S_GR = 2'd1;
    localparam logic [1:0] S_YE = 2'd2;
    localparam logic [1:0] S_FL = 2'd3;
    localparam logic [TW-1:0] MIN_L = TW'(MIN_GREEN);
    localparam logic [TW-1:0] MAX_L = TW'(MAX_GREEN);
    localparam logic [TW-1:0] YEL_L = TW'(YELLOW_T);
    localparam logic [TW-1:0] AR_L  = TW'(ALLRED_T);

    logic [1:0]      state_q, state_d, green_idx_q, green_idx_d, last_q, last_d, sel, cand;
    logic [TW-1:0]   timer_q, timer_d;
    logic            flash_q, flash_d, found, preempt, go_yellow;
    logic [3:0][2:0] lights_q, lights_d;
    logic [3:0]      demand, eligible, others, pref_el;

    assign demand   = req | pref;
    assign eligible = demand & ~force_red;
    assign others   = eligible & ~(4'b0001 << green_idx_q);
    assign pref_el  = pref & ~force_red;
`ifdef PHASE_SCHED_PREEMPT_EN
    assign preempt  = |(pref_el & ~(4'b0001 << green_idx_q));
`else
    assign preempt  = 1'b0;
`endif
    assign go_yellow = force_red[green_idx_q] | preempt
                     | (|others && ((timer_q >= MIN_L && !demand[green_idx_q]) || timer_q >= MAX_L));

    // Round-robin search upward from the approach after the last one served
    always_comb begin
        sel   = last_q;
        cand  = last_q;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!found && eligible[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
`ifdef PHASE_SCHED_PREEMPT_EN
        for (int i = 3; i >= 0; i--)
            if (pref_el[i]) sel = 2'(i);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_AR;
            timer_q     <= '0;
            green_idx_q <= 2'd0;
            last_q      <= 2'd3;
            flash_q     <= 1'b1;
            lights_q    <= {4{3'b100}};
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            green_idx_q <= green_idx_d;
            last_q      <= last_d;
            flash_q     <= flash_d;
            lights_q    <= lights_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        green_idx_d = green_idx_q;
        last_d      = last_q;
        if (attention) state_d = S_FL;
        else begin
            case (state_q)
                S_AR: if (timer_q >= AR_L && |eligible) begin
                    state_d     = S_GR;
                    green_idx_d = sel;
                    last_d      = sel;
                end
                S_GR:    state_d = go_yellow ? S_YE : S_GR;
                S_YE:    state_d = timer_q >= YEL_L ? S_AR : S_YE;
                default: state_d = S_AR;
            endcase
        end
        timer_d = state_d != state_q ? '0 : (tick && timer_q != '1) ? timer_q + TW'(1) : timer_q;
        flash_d = state_q != S_FL ? 1'b1 : tick ? ~flash_q : flash_q;
    end

    // Lamps are computed from the next state so they are registered alongside it
    always_comb begin
        lights_d = '0;
        for (int i = 0; i < 4; i++)
            lights_d[i] = state_d == S_FL ? {1'b0, flash_d, 1'b0}
                        : 2'(i) != green_idx_d ? 3'b100
                        : state_d == S_GR ? 3'b001
                        : state_d == S_YE ? 3'b010 : 3'b100;
    end

    assign lights    = lights_q;
    assign green_idx = green_idx_q;
    assign phase     = state_q;
endmodule

// File: tb/tb_phase_scheduler.sv
// tb_phase_scheduler: vector table, directed corner sequences and a randomized run against a behavioural model.
module tb_phase_scheduler;
    localparam int MIN_GREEN = 4, MAX_GREEN = 12, YELLOW_T = 3, ALLRED_T = 1;
    localparam logic [11:0] ALL_RED_L = 12'b100_100_100_100;
    localparam logic [11:0] ALL_YEL_L = 12'b010_010_010_010;

    logic clk = 1'b0, rst = 1'b1, tick = 1'b1, attention = 1'b0;
    logic [3:0] req = '0, pref = '0, force_red = '0;
    logic [3:0][2:0] lights;
    logic [1:0] green_idx, phase;
    int n_tests = 0, n_fail = 0;
    int m_ph, m_t, m_g, m_last;
    bit m_lit;

    phase_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick), .attention(attention), .req(req), .pref(pref),
        .force_red(force_red), .lights(lights), .green_idx(green_idx), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [1:0] ph;
        logic [1:0] g;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] lamps(input int ph, input int g, input bit lit);
        logic [11:0] r;
        for (int i = 0; i < 4; i++)
            r[i*3 +: 3] = ph == 3 ? (lit ? 3'b010 : 3'b000)
                        : (i == g && ph == 1) ? 3'b001
                        : (i == g && ph == 2) ? 3'b010 : 3'b100;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_init();
        m_ph = 0; m_t = 0; m_g = 0; m_last = 3; m_lit = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; pref = '0; force_red = '0; attention = 1'b0; tick = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_init();
    endtask

    task automatic wait_phase(input string name, input logic [1:0] p, input int lim);
        int k = 0;
        while (phase !== p && k < lim) begin
            step();
            k++;
        end
        check(name, 32'(phase), 32'(p));
    endtask

    // Reference: one clock of the scheduler rules applied to the current inputs
    task automatic model_step();
        int e, oth, sel, nxt;
        bit go, grant;
        e = int'((req | pref) & ~force_red);
        oth = e & ~(1 << m_g);
        nxt = m_ph; grant = 1'b0; sel = m_last;
        if (attention) nxt = 3;
        else if (m_ph == 0) begin
            if (m_t >= ALLRED_T && e != 0) begin
                for (int k = 4; k >= 1; k--)
                    if (e[(m_last + k) % 4]) sel = (m_last + k) % 4;
`ifdef PHASE_SCHED_PREEMPT_EN
                for (int k = 3; k >= 0; k--)
                    if (pref[k] && !force_red[k]) sel = k;
`endif
                nxt = 1; grant = 1'b1;
            end
        end else if (m_ph == 1) begin
            go = force_red[m_g] || (oth != 0 && m_t >= MAX_GREEN)
               || (oth != 0 && m_t >= MIN_GREEN && !(req[m_g] || pref[m_g]));
`ifdef PHASE_SCHED_PREEMPT_EN
            go = go || (((pref & ~force_red) & ~(4'b0001 << m_g)) != 4'b0);
`endif
            if (go) nxt = 2;
        end else if (m_ph == 2) begin
            if (m_t >= YELLOW_T) nxt = 0;
        end else nxt = 0;
        m_lit = (nxt == 3 && m_ph == 3) ? (tick ? !m_lit : m_lit) : 1'b1;
        m_t = (nxt != m_ph) ? 0 : tick ? (m_t < 255 ? m_t + 1 : 255) : m_t;
        if (grant) begin
            m_g = sel;
            m_last = sel;
        end
        m_ph = nxt;
    endtask

    initial begin
        int green_seen;
        tbl[0] = '{4'b0101, 2'd0, 2'd0};
        tbl[1] = '{4'b0101, 2'd1, 2'd0};
        for (int i = 2; i <= 5; i++) tbl[i] = '{4'b0100, 2'd1, 2'd0};
        for (int i = 6; i <= 9; i++) tbl[i] = '{4'b0100, 2'd2, 2'd0};
        tbl[10] = '{4'b0100, 2'd0, 2'd0};
        tbl[11] = '{4'b0100, 2'd0, 2'd0};
        tbl[12] = '{4'b0100, 2'd1, 2'd2};
        tbl[13] = '{4'b0100, 2'd1, 2'd2};

        do_reset();
        check("reset_phase", 32'(phase), 32'd0);
        check("reset_gidx", 32'(green_idx), 32'd0);
        check("reset_lights", 32'(lights), 32'(ALL_RED_L));

        // Approach 0 drops its demand once served, so MIN_GREEN governs its exit
        foreach (tbl[i]) begin
            req = tbl[i].req;
            step();
            check($sformatf("tbl%0d_phase", i), 32'(phase), 32'(tbl[i].ph));
            check($sformatf("tbl%0d_gidx", i), 32'(green_idx), 32'(tbl[i].g));
            check($sformatf("tbl%0d_lights", i), 32'(lights), 32'(lamps(tbl[i].ph, tbl[i].g, 1'b1)));
        end

        do_reset();
        req = 4'b0010;
        wait_phase("max_green_grant", 2'd1, 10);
        check("max_green_gidx", 32'(green_idx), 32'd1);
        repeat (19) step();
        check("hold_past_max", 32'(phase), 32'd1);
        req = 4'b1010;
        step();
        check("max_green_yellow", 32'(phase), 32'd2);
        wait_phase("max_green_next", 2'd1, 20);
        check("max_green_next_gidx", 32'(green_idx), 32'd3);

        do_reset();
        req = 4'b0001;
        wait_phase("force_grant", 2'd1, 10);
        step();
        force_red = 4'b0001;
        step();
        check("force_cut_yellow", 32'(phase), 32'd2);
        check("force_cut_lights", 32'(lights), 32'(lamps(2, 0, 1'b1)));
        green_seen = 0;
        repeat (30) begin
            step();
            if (phase == 2'd1) green_seen++;
        end
        check("force_never_green", 32'(green_seen), 32'd0);
        check("force_stay_allred", 32'(phase), 32'd0);

        do_reset();
        req = 4'b0011;
        wait_phase("pre_grant", 2'd1, 10);
        check("pre_grant_gidx", 32'(green_idx), 32'd0);
        step();
        pref = 4'b1000;
        step();
`ifdef PHASE_SCHED_PREEMPT_EN
        check("preempt_yellow", 32'(phase), 32'd2);
        wait_phase("preempt_grant", 2'd1, 20);
        check("preempt_gidx", 32'(green_idx), 32'd3);
`else
        check("no_preempt", 32'(phase), 32'd1);
`endif
        pref = '0;

        do_reset();
        req = 4'b0001;
        wait_phase("flash_pre", 2'd1, 10);
        attention = 1'b1;
        step();
        check("flash_phase", 32'(phase), 32'd3);
        check("flash_lit", 32'(lights), 32'(ALL_YEL_L));
        step();
        check("flash_dark", 32'(lights), 32'd0);
        step();
        check("flash_relit", 32'(lights), 32'(ALL_YEL_L));
        attention = 1'b0;
        step();
        check("flash_exit_phase", 32'(phase), 32'd0);
        check("flash_exit_lights", 32'(lights), 32'(ALL_RED_L));

        do_reset();
        req = 4'b0010;
        wait_phase("rst_pre_grant", 2'd1, 10);
        force_red = 4'b0010;
        step();
        step();
        check("rst_pre_yellow", 32'(phase), 32'd2);
        rst = 1'b1;
        #2;
        check("async_rst_lights", 32'(lights), 32'(ALL_RED_L));
        check("async_rst_phase", 32'(phase), 32'd0);
        check("async_rst_gidx", 32'(green_idx), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        force_red = '0;
        req = 4'b0101;
        wait_phase("restart_grant", 2'd1, 10);
        check("restart_gidx", 32'(green_idx), 32'd0);

        do_reset();
        for (int c = 0; c < 2500; c++) begin
            tick = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            if ($urandom_range(0, 15) == 0) pref = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0;
            if ($urandom_range(0, 31) == 0)
                force_red = $urandom_range(0, 1) != 0 ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
            attention = attention ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 99) == 0);
            model_step();
            step();
            check($sformatf("rand%0d_phase", c), 32'(phase), 32'(m_ph));
            check($sformatf("rand%0d_gidx", c), 32'(green_idx), 32'(m_g));
            check($sformatf("rand%0d_lights", c), 32'(lights), 32'(lamps(m_ph, m_g, m_lit)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
